// File: rtl/nc_pkg.sv
// Shared opcodes, reply bytes and sequencer state encoding for the NeuralChip
// command path.
package nc_pkg;

   localparam logic [7:0] NC_OP_LOAD  = 8'h10;  // low nibble carries the cell index
   localparam logic [7:0] NC_OP_START = 8'h20;
   localparam logic [7:0] NC_OP_READ  = 8'h30;
   localparam logic [7:0] NC_OP_STAT  = 8'h40;

   localparam logic [7:0] NC_ACK = 8'hAC;
   localparam logic [7:0] NC_NAK = 8'hEE;

   typedef enum logic [3:0] {
      IDLE,
      LOAD_ARG,
      STROBE,
      LAUNCH,
      WAIT_DONE,
      ACK,
      RD_HI,
      RD_LO,
      STAT
   } nc_state_t;

   function automatic logic is_busy(input nc_state_t s);
      return !(s == IDLE || s == LOAD_ARG);
   endfunction

endpackage

// File: rtl/nc_watchdog.sv
// Loadable down-counter that flags expiry once CYCLES enabled cycles have
// elapsed since the last load.
module nc_watchdog #(
   parameter int CYCLES = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic enable,
   output logic expired
);

   localparam int W = $clog2(CYCLES + 1);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= W'(CYCLES - 1);
      end else if (enable && count != '0) begin
         count <= count - W'(1);
      end
   end

   assign expired = enable && (count == '0);

endmodule

// File: rtl/nc_cmd_sequencer.sv
// Host command sequencer: parses UART bytes, drives array loads/launch and
// streams results back. Define NC_TIMEOUT_EN to enable the mult_done watchdog.
module nc_cmd_sequencer
   import nc_pkg::*;
#(
   parameter int ARR_CELLS      = 6,
   parameter int RES_COUNT      = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                         CLK,
   input  logic                         RESET,
   input  logic [7:0]                   rx_data,
   input  logic                         rx_valid,
   output logic [7:0]                   tx_data,
   output logic                         tx_valid,
   input  logic                         tx_ready,
   output logic [ARR_CELLS-1:0]         load_arr,
   output logic [7:0]                   load_data,
   output logic                         mult_start,
   input  logic                         mult_done,
   output logic [$clog2(RES_COUNT)-1:0] res_idx,
   input  logic [15:0]                  res_data,
   output logic                         busy,
   output logic                         err
);

   localparam int IDX_W = $clog2(RES_COUNT);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("nc_cmd_sequencer: TIMEOUT_CYCLES must be at least 1");
   end

   nc_state_t  state, state_d;
   logic [3:0] cell_q;
   logic [7:0] data_q;
   logic [7:0] stat_q;
   logic       nak_q;
   logic       err_d;
   logic       wd_expired;

   logic op_load, cell_ok, op_start, op_read, op_stat, res_last;

   assign op_load  = (rx_data[7:4] == NC_OP_LOAD[7:4]);
   assign cell_ok  = (int'(rx_data[3:0]) < ARR_CELLS);
   assign op_start = (rx_data == NC_OP_START);
   assign op_read  = (rx_data == NC_OP_READ);
   assign op_stat  = (rx_data == NC_OP_STAT);
   assign res_last = (res_idx == IDX_W'(RES_COUNT - 1));

`ifdef NC_TIMEOUT_EN
   nc_watchdog #(
      .CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (CLK),
      .rst_n   (RESET),
      .load    (state == LAUNCH),
      .enable  (state == WAIT_DONE),
      .expired (wd_expired)
   );
`else
   assign wd_expired = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   // NOTE: every combinational output gets a default first so no path can
   // fall through and infer a latch.
   always_comb begin
      state_d = state;
      err_d   = err;
      unique case (state)
         IDLE: begin
            if (rx_valid) begin
               if (op_load && cell_ok) state_d = LOAD_ARG;
               else if (op_start)      state_d = LAUNCH;
               else if (op_read)       state_d = RD_HI;
               else if (op_stat)       state_d = STAT;
               else                    err_d   = 1'b1;
            end
         end
         LOAD_ARG:  if (rx_valid) state_d = STROBE;
         STROBE:    state_d = IDLE;
         LAUNCH:    state_d = WAIT_DONE;
         WAIT_DONE: begin
            if (mult_done) begin
               state_d = ACK;
            end else if (wd_expired) begin
               state_d = ACK;
               err_d   = 1'b1;
            end
         end
         ACK:       if (tx_ready) state_d = IDLE;
         RD_HI:     if (tx_ready) state_d = RD_LO;
         RD_LO:     if (tx_ready) state_d = res_last ? IDLE : RD_HI;
         STAT: begin
            if (tx_ready) begin
               state_d = IDLE;
               err_d   = 1'b0;
            end
         end
         default:   state_d = IDLE;
      endcase
      // A byte arriving while busy always wins over the status clear.
      if (rx_valid && is_busy(state)) err_d = 1'b1;
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         cell_q  <= '0;
         data_q  <= '0;
         stat_q  <= '0;
         nak_q   <= 1'b0;
         res_idx <= '0;
         err     <= 1'b0;
      end else begin
         err <= err_d;
         if (state == IDLE && rx_valid) begin
            if (op_load && cell_ok) cell_q <= rx_data[3:0];
            if (op_stat)            stat_q <= {err, 6'b0, is_busy(state)};
            if (op_read)            res_idx <= '0;
         end
         if (state == LOAD_ARG && rx_valid) data_q <= rx_data;
         if (state == WAIT_DONE)            nak_q  <= !mult_done && wd_expired;
         if (state == RD_LO && tx_ready)    res_idx <= res_last ? '0 : res_idx + IDX_W'(1);
      end
   end

   always_comb begin
      busy       = is_busy(state);
      tx_valid   = 1'b0;
      tx_data    = '0;
      load_arr   = '0;
      load_data  = '0;
      mult_start = 1'b0;
      unique case (state)
         STROBE: begin
            load_arr  = ARR_CELLS'(1) << cell_q;
            load_data = data_q;
         end
         LAUNCH: mult_start = 1'b1;
         ACK: begin
            tx_valid = 1'b1;
            tx_data  = nak_q ? NC_NAK : NC_ACK;
         end
         RD_HI: begin
            tx_valid = 1'b1;
            tx_data  = res_data[15:8];
         end
         RD_LO: begin
            tx_valid = 1'b1;
            tx_data  = res_data[7:0];
         end
         STAT: begin
            tx_valid = 1'b1;
            tx_data  = stat_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_nc_cmd_sequencer.sv
// Directed bench for nc_cmd_sequencer; TX bytes are checked against a
// scoreboard queue filled when each command is issued.
module tb_nc_cmd_sequencer;
   import nc_pkg::*;

   logic        CLK;
   logic        RESET;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [5:0]  load_arr;
   logic [7:0]  load_data;
   logic        mult_start;
   logic        mult_done;
   logic [1:0]  res_idx;
   logic [15:0] res_data;
   logic        busy;
   logic        err;

   int          checks = 0;
   int          errors = 0;
   int          ready_mode = 0;  // 0: always ready, 1: toggle every 3 cycles
   logic [7:0]  sb[$];

   nc_cmd_sequencer #(
      .ARR_CELLS      (6),
      .RES_COUNT      (4),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .load_arr   (load_arr),
      .load_data  (load_data),
      .mult_start (mult_start),
      .mult_done  (mult_done),
      .res_idx    (res_idx),
      .res_data   (res_data),
      .busy       (busy),
      .err        (err)
   );

   // Array model: result at index i is i*0x0101 + 0x1000.
   assign res_data = 16'h1000 + 16'h0101 * 16'(res_idx);

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      step();
      rx_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      while (busy !== 1'b0 && n < budget) begin
         step();
         n++;
      end
      check(tag, 32'(busy), 32'd0);
   endtask

   initial begin
      int cnt = 0;
      tx_ready = 1'b1;
      forever begin
         step();
         if (ready_mode == 1) begin
            cnt++;
            if (cnt >= 3) begin
               cnt      = 0;
               tx_ready = ~tx_ready;
            end
         end else begin
            tx_ready = 1'b1;
         end
      end
   end

   // TX monitor: pops expected bytes on each accept and checks hold stability.
   initial begin
      logic       pending = 1'b0;
      logic [7:0] held    = '0;
      logic [7:0] e;
      forever begin
         @(negedge CLK);
         if (RESET && tx_valid) begin
            if (pending) check("tx_hold_stable", 32'(tx_data), 32'(held));
            if (tx_ready) begin
               e = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
               check("tx_byte", 32'(tx_data), 32'(e));
               pending = 1'b0;
            end else begin
               pending = 1'b1;
               held    = tx_data;
            end
         end else begin
            pending = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      RESET     = 1'b0;
      rx_valid  = 1'b0;
      rx_data   = '0;
      mult_done = 1'b0;
      #12;
      check("rst_tx_valid", 32'(tx_valid), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      check("rst_load_arr", 32'(load_arr), 32'd0);
      check("rst_load_data", 32'(load_data), 32'd0);
      check("rst_mult_start", 32'(mult_start), 32'd0);
      check("rst_res_idx", 32'(res_idx), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      step();
      RESET = 1'b1;
      step();

      // Load cell 2 with 0x5A
      send_byte(8'h12);
      check("load_arg_no_strobe", 32'(load_arr), 32'd0);
      check("load_arg_not_busy", 32'(busy), 32'd0);
      send_byte(8'h5A);
      check("load_arr", 32'(load_arr), 32'b000100);
      check("load_data", 32'(load_data), 32'h5A);
      check("load_err", 32'(err), 32'd0);
      step();
      check("load_strobe_one_cycle", 32'(load_arr), 32'd0);
      check("load_done_idle", 32'(busy), 32'd0);

      // Multiply, done 10 cycles after launch
      sb.push_back(NC_ACK);
      send_byte(NC_OP_START);
      check("mult_start_pulse", 32'(mult_start), 32'd1);
      step();
      check("mult_start_single", 32'(mult_start), 32'd0);
      check("wait_busy", 32'(busy), 32'd1);
      repeat (9) step();
      check("wait_no_tx", 32'(tx_valid), 32'd0);
      mult_done = 1'b1;
      step();
      mult_done = 1'b0;
      check("ack_valid", 32'(tx_valid), 32'd1);
      // Byte in the final-accept cycle is discarded and flagged
      send_byte(NC_OP_STAT);
      check("final_accept_idle", 32'(busy), 32'd0);
      check("final_accept_no_tx", 32'(tx_valid), 32'd0);
      check("final_accept_err", 32'(err), 32'd1);
      check("ack_sb_empty", sb.size(), 32'd0);
      sb.push_back(8'h80);
      send_byte(NC_OP_STAT);
      wait_idle("stat1_idle", 10);
      check("stat1_err_cleared", 32'(err), 32'd0);

      // Done coinciding with launch is ignored; byte during WAIT_DONE flags err
      send_byte(NC_OP_START);
      mult_done = 1'b1;
      step();
      mult_done = 1'b0;
      repeat (3) step();
      check("early_done_ignored", 32'(tx_valid), 32'd0);
      check("early_done_busy", 32'(busy), 32'd1);
      send_byte(8'h33);
      check("busy_rx_err", 32'(err), 32'd1);
      check("busy_rx_still_wait", 32'(busy), 32'd1);
      check("busy_rx_no_tx", 32'(tx_valid), 32'd0);
      sb.push_back(NC_ACK);
      mult_done = 1'b1;
      step();
      mult_done = 1'b0;
      wait_idle("ack2_idle", 10);
      sb.push_back(8'h80);
      send_byte(NC_OP_STAT);
      wait_idle("stat2_idle", 10);
      check("stat2_err_cleared", 32'(err), 32'd0);

      // Out-of-range cell and unknown opcode
      send_byte(8'h17);
      check("bad_cell_err", 32'(err), 32'd1);
      check("bad_cell_idle", 32'(busy), 32'd0);
      check("bad_cell_no_strobe", 32'(load_arr), 32'd0);
      sb.push_back(8'h80);
      send_byte(NC_OP_STAT);
      wait_idle("stat3_idle", 10);
      check("stat3_err_cleared", 32'(err), 32'd0);
      send_byte(8'h99);
      check("bad_op_err", 32'(err), 32'd1);
      sb.push_back(8'h80);
      send_byte(NC_OP_STAT);
      wait_idle("stat4_idle", 10);
      check("stat4_err_cleared", 32'(err), 32'd0);
      check("stat_sb_empty", sb.size(), 32'd0);

      // Readout with tx_ready toggling every 3 cycles
      ready_mode = 1;
      for (int i = 0; i < 4; i++) begin
         sb.push_back(8'h10 + 8'(i));
         sb.push_back(8'(i));
      end
      send_byte(NC_OP_READ);
      wait_idle("read_idle", 100);
      check("read_sb_empty", sb.size(), 32'd0);
      check("read_idx_wrap", 32'(res_idx), 32'd0);
      check("read_err", 32'(err), 32'd0);

      // Reset after the second TX byte aborts at once
      ready_mode = 0;
      step();
      step();
      sb.push_back(8'h10);
      sb.push_back(8'h00);
      send_byte(NC_OP_READ);
      step();
      step();
      RESET = 1'b0;
      #1;
      check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
      check("mid_rst_tx_data", 32'(tx_data), 32'd0);
      check("mid_rst_res_idx", 32'(res_idx), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_load_arr", 32'(load_arr), 32'd0);
      check("mid_rst_mult_start", 32'(mult_start), 32'd0);
      check("mid_rst_sb_empty", sb.size(), 32'd0);
      #2;
      RESET = 1'b1;
      step();
      for (int i = 0; i < 4; i++) begin
         sb.push_back(8'h10 + 8'(i));
         sb.push_back(8'(i));
      end
      send_byte(NC_OP_READ);
      wait_idle("reread_idle", 40);
      check("reread_sb_empty", sb.size(), 32'd0);

`ifdef NC_TIMEOUT_EN
      // Watchdog expiry replaces the ACK with a NAK
      sb.push_back(NC_NAK);
      send_byte(NC_OP_START);
      wait_idle("timeout_idle", 40);
      check("timeout_err", 32'(err), 32'd1);
      check("timeout_sb_empty", sb.size(), 32'd0);
      sb.push_back(8'h80);
      send_byte(NC_OP_STAT);
      wait_idle("stat5_idle", 10);
      check("stat5_err_cleared", 32'(err), 32'd0);
`endif

      step();
      check("final_sb_empty", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/nc_cmd_sequencer.md
# nc_cmd_sequencer

Command sequencer between the UART byte interface and the NeuralChip multiply array. Parses host command bytes, drives one-hot cell load strobes with data, launches a multiply and waits for completion, then streams 16-bit results back as TX bytes. It is the single owner of the array's load, start and result-read ports; no other block drives them.

## Interface
- `ARR_CELLS`, 6: number of loadable array cells; width of `load_arr`.
- `RES_COUNT`, 4: number of 16-bit results returned per read command.
- `TIMEOUT_CYCLES`, 1024: watchdog limit for `mult_done`; used only when `NC_TIMEOUT_EN` is defined.

Ports:
- `CLK`  in  1  system clock; all logic on rising edge.
- `RESET`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  received byte; valid only when `rx_valid` is high.
- `rx_valid`  in  1  one-cycle strobe, one per byte.
- `tx_data`  out  8  byte to transmit.
- `tx_valid`  out  1  TX request.
- `tx_ready`  in  1  UART TX accepts the byte.
- `load_arr`  out  ARR_CELLS  one-hot, single-cycle cell load strobe.
- `load_data`  out  8  data for the strobed cell.
- `mult_start`  out  1  single-cycle multiply launch.
- `mult_done`  in  1  array completion; level or pulse.
- `res_idx`  out  clog2(RES_COUNT)  result select.
- `res_data`  in  16  result at `res_idx`; combinational from the array.
- `busy`  out  1  high in every state except IDLE and LOAD_ARG.
- `err`  out  1  sticky error flag.

## Operation
- Opcodes:
  - 0x10+k: load cell k. The next `rx_valid` byte is the data. If k ≥ `ARR_CELLS`, set `err`, drop the command and stay in IDLE.
  - 0x20: start multiply.
  - 0x30: read all results.
  - 0x40: status. Returns byte {err, 6'b0, busy}, then clears `err`.
  - Any other byte: set `err`, stay in IDLE.
- States and transitions:
  - IDLE → LOAD_ARG on opcode 0x1k with k valid.
  - LOAD_ARG → STROBE on the data byte.
  - STROBE → IDLE after one cycle.
  - IDLE → LAUNCH → WAIT_DONE on 0x20.
  - WAIT_DONE → ACK on `mult_done`.
  - ACK → IDLE when the ACK byte is accepted.
  - IDLE → RD_HI on 0x30.
  - RD_HI → RD_LO → RD_HI, repeated for each `res_idx`.
  - RD_LO → IDLE after the last `res_idx`.
  - IDLE → STAT → IDLE on 0x40.
- Result readout: for each `res_idx` from 0 to `RES_COUNT`-1, send `res_data[15:8]` then `res_data[7:0]`. `res_idx` is held stable across both bytes and increments after the LO byte is accepted.
- ACK byte is 0xAC, sent once per completed multiply.
- Any `rx_valid` while `busy` is high: the byte is discarded and `err` is set.

## Timing
- Reset values: `tx_valid`=0, `tx_data`=0, `load_arr`=0, `load_data`=0, `mult_start`=0, `res_idx`=0, `busy`=0, `err`=0; state IDLE.
- Reset asserted mid-operation aborts immediately. Nothing is resumed after reset.
- Load: `load_arr[k]` and `load_data` are valid in the cycle after the data byte's `rx_valid`. The strobe lasts exactly one cycle.
- Start: `mult_start` pulses for one cycle, the cycle after the 0x20 `rx_valid`.
  - `mult_done` is sampled from the cycle after `mult_start`. A `mult_done` coinciding with `mult_start` is ignored.
- TX handshake:
  - `tx_data` is stable while `tx_valid` is high. `tx_valid` stays high until a rising edge with `tx_ready`=1.
  - The next byte may be presented the following cycle.
  - `tx_ready` high while `tx_valid` is low has no effect.
- `rx_valid` in IDLE and in the cycle of the final TX accept:
  - In IDLE it is always accepted.
  - In the final-accept cycle it is treated as busy and discarded.

## Configuration
- `NC_TIMEOUT_EN` defined:
  - A counter runs in WAIT_DONE.
  - On reaching `TIMEOUT_CYCLES` without `mult_done`: set `err`, send 0xEE instead of 0xAC, return to IDLE.
- `NC_TIMEOUT_EN` not defined: WAIT_DONE waits indefinitely and 0xEE is never sent.

## Structure
- Package `nc_pkg` holds:
  - opcode constants `NC_OP_LOAD`, `NC_OP_START`, `NC_OP_READ`, `NC_OP_STAT`;
  - `NC_ACK`=0xAC and `NC_NAK`=0xEE;
  - the state enum `nc_state_t`.
- Sub-module `nc_watchdog` is a loadable down-counter with an expiry flag. It is instantiated only under `NC_TIMEOUT_EN`.

## Test plan
- Load path: send 0x12 then 0x5A → one cycle with `load_arr`=6'b000100 and `load_data`=0x5A. `err`=0.
- Multiply: send 0x20 → one-cycle `mult_start` pulse. Raise `mult_done` 10 cycles later → `tx_data`=0xAC. Then `busy` falls.
- Readout: `res_data`=idx·0x0101+0x1000, 0x30 sent, `tx_ready` toggled every 3 cycles → TX bytes 10 00 11 01 12 02 13 03, with no byte lost while waiting.
- Errors:
  - Send 0x17 (out-of-range cell) → `err`=1.
  - Then send 0x40 → TX byte 0x80, after which `err`=0.
  - Send a byte during WAIT_DONE → `err` set; state unchanged.
- Timeout (with `NC_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16): send 0x20 and never raise `mult_done` → TX 0xEE at roughly 16 cycles, `err`=1.
- Reset mid-readout: assert `RESET` low after the second TX byte → all outputs 0 within the same cycle. A following 0x30 restarts from `res_idx`=0.
